regf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port among NUM_REQ writeback sources,
//  e.g. the in-order WB stage and a multi-cycle mul/div unit.
//  - One write per cycle, selected round-robin.
//  - Per-requester valid/ready handshake; registered output stage.
//  - Output drives the regfile signals regf_we / rd_s_wb / rd_v_wb.

---
 rtl/regf_wb_arbiter.sv | 83 ++++++++
 tb/tb_regf_wb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regf_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NUM_REQ writeback sources.
// Optional REGF_WB_ARB_X0_DROP_EN: x0 writes are accepted and dropped without arbitrating.
module regf_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_rd_s,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_rd_v,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             regf_we,
    output logic [ADDR_W-1:0]                rd_s_wb,
    output logic [DATA_W-1:0]                rd_v_wb,
    output logic [$clog2(NUM_REQ)-1:0]       rr_ptr_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   nxt_ptr;
    logic               found;
    logic [NUM_REQ-1:0] drop;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    int                 idx;

`ifdef REGF_WB_ARB_X0_DROP_EN
    always_comb begin
        drop = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            drop[i] = req_valid[i] && (req_rd_s[i] == '0);
        end
    end
`else
    assign drop = '0;
`endif

    assign elig = req_valid & ~drop;

    // Scan from rr_ptr upward, wrapping at NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && elig[idx]) begin
                found      = 1'b1;
                win        = PTR_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    assign nxt_ptr   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    assign req_ready = rst_n ? (grant | drop) : '0;
    assign rr_ptr_o  = rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regf_we <= 1'b0;
            rd_s_wb <= '0;
            rd_v_wb <= '0;
            rr_ptr  <= '0;
        end else begin
            regf_we <= found;
            if (found) begin
                rd_s_wb <= req_rd_s[win];
                rd_v_wb <= req_rd_v[win];
                rr_ptr  <= nxt_ptr;
            end
        end
    end

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// Directed bench for regf_wb_arbiter: a 2-requester and a 4-requester instance.
module tb_regf_wb_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]       v2 = '0;
    logic [1:0][4:0]  s2 = '0;
    logic [1:0][31:0] d2 = '0;
    logic [1:0]       rdy2;
    logic             we2;
    logic [4:0]       rs2;
    logic [31:0]      rv2;
    logic [0:0]       p2;

    logic [3:0]       v4 = '0;
    logic [3:0][4:0]  s4 = '0;
    logic [3:0][31:0] d4 = '0;
    logic [3:0]       rdy4;
    logic             we4;
    logic [4:0]       rs4;
    logic [31:0]      rv4;
    logic [1:0]       p4;

    logic [31:0] rf [32];
    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regf_wb_arbiter #(.NUM_REQ(2), .DATA_W(32), .ADDR_W(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_rd_s(s2),
        .req_rd_v(d2), .req_ready(rdy2), .regf_we(we2), .rd_s_wb(rs2),
        .rd_v_wb(rv2), .rr_ptr_o(p2)
    );

    regf_wb_arbiter #(.NUM_REQ(4), .DATA_W(32), .ADDR_W(5)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_rd_s(s4),
        .req_rd_v(d4), .req_ready(rdy4), .regf_we(we4), .rd_s_wb(rs4),
        .rd_v_wb(rv4), .rr_ptr_o(p4)
    );

    always @(posedge clk) begin
        if (we2) rf[rs2] <= rv2;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // reset state, ready suppressed while held
        v2 = 2'b11;
        v4 = 4'b1111;
        step();
        step();
        #1;
        chk("rst_rdy2", rdy2, 2'b00);
        chk("rst_rdy4", rdy4, 4'b0000);
        chk("rst_we2", we2, 0);
        chk("rst_rs2", rs2, 0);
        chk("rst_rv2", rv2, 0);
        chk("rst_ptr2", p2, 0);
        chk("rst_we4", we4, 0);
        chk("rst_ptr4", p4, 0);
        v2 = '0;
        v4 = '0;
        rst_n = 1'b1;
        step();

        // single requester
        v2 = 2'b01; s2[0] = 5'd5; d2[0] = 32'hDEADBEEF;
        #1 chk("t2_rdy", rdy2, 2'b01);
        step();
        chk("t2_we", we2, 1);
        chk("t2_rs", rs2, 5);
        chk("t2_rv", rv2, 32'hDEADBEEF);
        chk("t2_ptr", p2, 1);
        v2 = 2'b00;
        #1 chk("idle_rdy", rdy2, 2'b00);
        step();
        chk("idle_we", we2, 0);
        chk("idle_rs", rs2, 5);
        chk("idle_ptr", p2, 1);

        // bring rr_ptr back to 0 via a grant to req1
        v2 = 2'b10; s2[1] = 5'd1; d2[1] = 32'h1;
        step();
        chk("wrap_ptr", p2, 0);

        // contention: alternate 3,4,3,4
        s2[0] = 5'd3; d2[0] = 32'h11;
        s2[1] = 5'd4; d2[1] = 32'h22;
        v2 = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t3_rdy", rdy2, (k % 2 == 0) ? 2'b01 : 2'b10);
            step();
            chk("t3_we", we2, 1);
            chk("t3_rs", rs2, (k % 2 == 0) ? 3 : 4);
            chk("t3_rv", rv2, (k % 2 == 0) ? 32'h11 : 32'h22);
            chk("t3_ptr", p2, (k % 2 == 0) ? 1 : 0);
        end

        // same-rd conflict with rr_ptr=1
        v2 = 2'b01;
        step();
        chk("t4_ptr", p2, 1);
        s2[0] = 5'd7; d2[0] = 32'hA;
        s2[1] = 5'd7; d2[1] = 32'hB;
        v2 = 2'b11;
        #1 chk("t4_rdy1", rdy2, 2'b10);
        step();
        chk("t4_rv1", rv2, 32'hB);
        chk("t4_rs1", rs2, 7);
        v2 = 2'b01;
        #1 chk("t4_rdy2", rdy2, 2'b01);
        step();
        chk("t4_rv2", rv2, 32'hA);
        chk("t4_we2", we2, 1);
        v2 = 2'b00;
        step();
        chk("t4_x7", rf[7], 32'hA);

        // async reset mid-stream, right after a grant
        v2 = 2'b01; s2[0] = 5'd11; d2[0] = 32'h77;
        step();
        chk("t1_we_pre", we2, 1);
        v2 = 2'b10; s2[1] = 5'd12; d2[1] = 32'hC;
        #1 chk("t1_rdy_pre", rdy2, 2'b10);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_rdy", rdy2, 2'b00);
        chk("t1_we", we2, 0);
        chk("t1_ptr", p2, 0);
        step();
        chk("t1_we_n1", we2, 0);
        chk("t1_rs_n1", rs2, 0);
        v2 = 2'b00;
        rst_n = 1'b1;
        step();

        // x0 write alongside rd 9
        s2[0] = 5'd0; d2[0] = 32'h55;
        s2[1] = 5'd9; d2[1] = 32'h99;
        v2 = 2'b11;
`ifdef REGF_WB_ARB_X0_DROP_EN
        #1 chk("t6_rdy", rdy2, 2'b11);
        step();
        chk("t6_we", we2, 1);
        chk("t6_rs", rs2, 9);
        chk("t6_rv", rv2, 32'h99);
        chk("t6_ptr", p2, 0);
        v2 = 2'b00;
`else
        #1 chk("t6_rdy0", rdy2, 2'b01);
        step();
        chk("t6_we0", we2, 1);
        chk("t6_rs0", rs2, 0);
        chk("t6_rv0", rv2, 32'h55);
        v2 = 2'b10;
        #1 chk("t6_rdy1", rdy2, 2'b10);
        step();
        chk("t6_rs1", rs2, 9);
        chk("t6_rv1", rv2, 32'h99);
        chk("t6_ptr", p2, 0);
        v2 = 2'b00;
`endif
        step();
        chk("t6_we_end", we2, 0);
        chk("t6_rs_hold", rs2, 9);

        // fairness with four requesters
        for (int i = 0; i < 4; i++) begin
            s4[i] = 5'(i + 1);
            d4[i] = 32'h100 + 32'(i);
        end
        v4 = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 chk("t5_rdy", rdy4, 4'b0001 << (k % 4));
            step();
            chk("t5_we", we4, 1);
            chk("t5_rs", rs4, (k % 4) + 1);
            chk("t5_rv", rv4, 32'h100 + (k % 4));
            chk("t5_ptr", p4, (k + 1) % 4);
        end
        v4 = 4'b0000;
        step();
        chk("t5_we_end", we4, 0);
        chk("t5_ptr_end", p4, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
